// File: rtl/sm_pkg.sv
// Shared types for the state_machine burst sequencer: FSM state encoding and the
// captured-output width, plus the phase-skip rule used whenever a LOW/HIGH pair starts.
package sm_pkg;

  localparam int SM_OUT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    SMRST,
    LOW,
    HIGH,
    CAP,
    FIN
  } sm_seq_state_e;

  // A zero-length phase is skipped entirely, so a pair may start directly in HIGH or CAP.
  function automatic sm_seq_state_e first_phase(input logic low_nz, input logic high_nz);
    if (low_nz) begin
      return LOW;
    end else if (high_nz) begin
      return HIGH;
    end
    return CAP;
  endfunction

endpackage

// File: rtl/sm_cap_buf.sv
// One-entry valid/ready holding register for captured state_machine outputs; zero-latency accept.
// Accepts when empty or draining this cycle (in_rdy depends combinationally on out_rdy); a write during a drain replaces the data.
module sm_cap_buf
  import sm_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                in_vld,
  input  logic [SM_OUT_W-1:0] in_dat,
  output logic                in_rdy,
  output logic                out_vld,
  output logic [SM_OUT_W-1:0] out_dat,
  input  logic                out_rdy
);

  logic                vld_q, vld_d;
  logic [SM_OUT_W-1:0] dat_q, dat_d;

  assign in_rdy = !vld_q || out_rdy;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (vld_q && out_rdy) begin
      vld_d = 1'b0;
    end
    if (in_vld && in_rdy) begin
      vld_d = 1'b1;
      dat_d = in_dat;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q;
  assign out_dat = dat_q;

endmodule

// File: rtl/sm_sequencer.sv
// Drives a state_machine through reset, LOW/HIGH input bursts and output captures; outputs registered, done 1 cycle after last capture.
// Stalls in CAP while the capture buffer is full and cap_ready_i is low; abort_i forces FIN with the state_machine held in reset.
module sm_sequencer
  import sm_pkg::*;
#(
  parameter int CW      = 8,
  parameter int RST_CYC = 2
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [CW-1:0]       low_len_i,
  input  logic [CW-1:0]       high_len_i,
  input  logic [3:0]          rep_i,
  input  logic [SM_OUT_W-1:0] sm_out_i,
  output logic                sm_in_o,
  output logic                sm_reset_o,
  output logic                cap_valid_o,
  output logic [SM_OUT_W-1:0] cap_data_o,
  input  logic                cap_ready_i,
  output logic                busy_o,
  output logic                done_o
);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);

  sm_seq_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] low_q, low_d;
  logic [CW-1:0] high_q, high_d;
  logic [3:0]    rep_q, rep_d;
  logic          sm_in_q, sm_in_d;
  logic          sm_reset_q, sm_reset_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          abort_fin;
  logic          cap_fire;
  logic          buf_rdy;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    low_d     = low_q;
    high_d    = high_q;
    rep_d     = rep_q;
    abort_fin = 1'b0;
    cap_fire  = 1'b0;

    // FIN is already on its way back to IDLE, so abort only matters in the working states.
    if (abort_i && state_q != IDLE && state_q != FIN) begin
      state_d   = FIN;
      abort_fin = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            low_d   = low_len_i;
            high_d  = high_len_i;
            rep_d   = (rep_i == 4'd0) ? 4'd1 : rep_i;
            cnt_d   = RST_LAST;
            state_d = SMRST;
          end
        end
        SMRST, CAP: begin
          if ((state_q == SMRST && cnt_q == '0) || (state_q == CAP && buf_rdy)) begin
            if (state_q == CAP) begin
              cap_fire = 1'b1;
              rep_d    = rep_q - 4'd1;
            end
            if (state_q == CAP && rep_q == 4'd1) begin
              state_d = FIN;
            end else begin
              state_d = first_phase(low_q != '0, high_q != '0);
              if (low_q != '0) begin
                cnt_d = low_q - CNT_ONE;
              end else if (high_q != '0) begin
                cnt_d = high_q - CNT_ONE;
              end else begin
                cnt_d = '0;
              end
            end
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        LOW: begin
          if (cnt_q == '0) begin
            if (high_q != '0) begin
              state_d = HIGH;
              cnt_d   = high_q - CNT_ONE;
            end else begin
              state_d = CAP;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        HIGH: begin
          if (cnt_q == '0) begin
            state_d = CAP;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    sm_in_d    = (state_d == HIGH);
    sm_reset_d = (state_d == SMRST) || abort_fin;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FIN);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      low_q      <= '0;
      high_q     <= '0;
      rep_q      <= '0;
      sm_in_q    <= 1'b0;
      sm_reset_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      low_q      <= low_d;
      high_q     <= high_d;
      rep_q      <= rep_d;
      sm_in_q    <= sm_in_d;
      sm_reset_q <= sm_reset_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  sm_cap_buf u_cap_buf (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .in_vld   (cap_fire),
    .in_dat   (sm_out_i),
    .in_rdy   (buf_rdy),
    .out_vld  (cap_valid_o),
    .out_dat  (cap_data_o),
    .out_rdy  (cap_ready_i)
  );

  assign sm_in_o    = sm_in_q;
  assign sm_reset_o = sm_reset_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_sm_sequencer.sv
// Table-driven bench for sm_sequencer with a capture scoreboard and hand-written corner sequences.
module tb_sm_sequencer;

  localparam int CW      = 8;
  localparam int RST_CYC = 2;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic          start_i;
  logic          abort_i;
  logic [CW-1:0] low_len_i;
  logic [CW-1:0] high_len_i;
  logic [3:0]    rep_i;
  logic [2:0]    sm_out_i;
  logic          sm_in_o;
  logic          sm_reset_o;
  logic          cap_valid_o;
  logic [2:0]    cap_data_o;
  logic          cap_ready_i;
  logic          busy_o;
  logic          done_o;

  always #5 clk_i = ~clk_i;

  sm_sequencer #(.CW(CW), .RST_CYC(RST_CYC)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .low_len_i   (low_len_i),
    .high_len_i  (high_len_i),
    .rep_i       (rep_i),
    .sm_out_i    (sm_out_i),
    .sm_in_o     (sm_in_o),
    .sm_reset_o  (sm_reset_o),
    .cap_valid_o (cap_valid_o),
    .cap_data_o  (cap_data_o),
    .cap_ready_i (cap_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  typedef struct {
    int low;
    int high;
    int rep;
    int exp_done;
    int exp_caps;
  } vec_t;

  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  int         hs_cnt      = 0;
  logic [2:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Outputs as {busy, done, sm_reset, sm_in}
  function automatic int outs();
    return int'({busy_o, done_o, sm_reset_o, sm_in_o});
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    sm_out_i = 3'((cyc * 3 + 1) % 8);
  endtask

  // Handshake monitor: a transfer happens at the next rising edge.
  always @(negedge clk_i) begin
    if (reset_ni && cap_valid_o && cap_ready_i) begin
      hs_cnt++;
      chk("cap_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("cap_data", int'(cap_data_o), int'(exp_q.pop_front()));
    end
  end

  task automatic run_burst(input int low, input int high, input int rep,
                           input int exp_done, input int exp_caps);
    int reps, per, t, j, hs0, done_at, e;
    reps = (rep == 0) ? 1 : rep;
    per  = low + high + 1;
    t    = RST_CYC + reps * per;
    hs0  = hs_cnt;
    done_at = -1;
    cap_ready_i = 1'b1;
    low_len_i   = CW'(low);
    high_len_i  = CW'(high);
    rep_i       = 4'(rep);
    start_i     = 1'b1;
    for (int k = 0; k <= t + 2; k++) begin
      step();
      start_i = (k == 2);
      if (k == 0) begin
        low_len_i  = 8'd7;
        high_len_i = 8'd9;
        rep_i      = 4'd5;
      end
      if (done_o) done_at = k;
      if (k < RST_CYC) begin
        e = 4'b1010;
      end else if (k < t) begin
        j = (k - RST_CYC) % per;
        e = (j >= low && j < low + high) ? 4'b1001 : 4'b1000;
        if (j == low + high) exp_q.push_back(sm_out_i);
      end else if (k == t) begin
        e = 4'b1100;
      end else begin
        e = 4'b0000;
      end
      chk($sformatf("burst_l%0d_h%0d_r%0d_k%0d", low, high, rep, k), outs(), e);
    end
    chk($sformatf("done_cycle_l%0d_h%0d_r%0d", low, high, rep), done_at, exp_done);
    chk($sformatf("handshakes_l%0d_h%0d_r%0d", low, high, rep), hs_cnt - hs0, exp_caps);
  endtask

  vec_t tbl[6];
  logic [3:0] ab_exp [0:13];
  logic [2:0] first;
  int hs0, e;

  initial begin
    tbl[0] = '{3, 4, 1, 10, 1};
    tbl[1] = '{1, 2, 3, 14, 3};
    tbl[2] = '{0, 0, 0, 3, 1};
    tbl[3] = '{0, 0, 3, 5, 3};
    tbl[4] = '{0, 3, 2, 10, 2};
    tbl[5] = '{2, 0, 1, 5, 1};

    start_i = 0; abort_i = 0; low_len_i = '0; high_len_i = '0; rep_i = '0;
    sm_out_i = '0; cap_ready_i = 1'b1;
    reset_ni = 1'b1;
    #2 reset_ni = 1'b0;
    #1;
    chk("reset_outs", int'({sm_in_o, sm_reset_o, cap_valid_o, cap_data_o, busy_o, done_o}),
        int'(8'b0_1_0_000_0_0));
    step(); step();
    reset_ni = 1'b1;
    step();
    chk("post_reset_outs", outs(), 4'b0000);
    chk("post_reset_valid", int'(cap_valid_o), 0);

    foreach (tbl[i]) run_burst(tbl[i].low, tbl[i].high, tbl[i].rep, tbl[i].exp_done, tbl[i].exp_caps);

    // Backpressure: second capture must wait in CAP until the first is taken.
    cap_ready_i = 1'b0;
    low_len_i = 8'd1; high_len_i = 8'd1; rep_i = 4'd2; start_i = 1'b1;
    hs0 = hs_cnt;
    first = '0;
    for (int k = 0; k <= 22; k++) begin
      step();
      start_i = 1'b0;
      if (k == 4) begin
        exp_q.push_back(sm_out_i);
        first = sm_out_i;
      end
      if (k == 19) begin
        cap_ready_i = 1'b1;
        exp_q.push_back(sm_out_i);
      end
      if (k < 2) e = 4'b1010;
      else if (k == 3 || k == 6) e = 4'b1001;
      else if (k <= 19) e = 4'b1000;
      else if (k == 20) e = 4'b1100;
      else e = 4'b0000;
      chk($sformatf("stall_k%0d", k), outs(), e);
      if (k >= 5 && k <= 19) chk($sformatf("stall_hold_k%0d", k), int'({cap_valid_o, cap_data_o}), int'({1'b1, first}));
    end
    chk("stall_handshakes", hs_cnt - hs0, 2);

    // Abort in HIGH, start while busy, abort in IDLE, then start+abort together in IDLE.
    ab_exp = '{4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1110,
               4'b0000, 4'b0000, 4'b1010, 4'b1010, 4'b1000, 4'b1100, 4'b0000};
    low_len_i = 8'd2; high_len_i = 8'd5; rep_i = 4'd1; start_i = 1'b1;
    hs0 = hs_cnt;
    for (int k = 0; k <= 13; k++) begin
      step();
      start_i = 1'b0;
      abort_i = 1'b0;
      if (k == 5) begin
        abort_i = 1'b1;
        start_i = 1'b1;
      end
      if (k == 7) abort_i = 1'b1;
      if (k == 8) begin
        abort_i = 1'b1; start_i = 1'b1;
        low_len_i = '0; high_len_i = '0; rep_i = 4'd1;
      end
      if (k == 11) exp_q.push_back(sm_out_i);
      chk($sformatf("abort_k%0d", k), outs(), int'(ab_exp[k]));
      if (k >= 6 && k <= 8) chk($sformatf("abort_no_cap_k%0d", k), int'(cap_valid_o), 0);
    end
    chk("abort_handshakes", hs_cnt - hs0, 1);

    // Reset mid-burst with a capture still buffered.
    cap_ready_i = 1'b0;
    low_len_i = 8'd1; high_len_i = 8'd1; rep_i = 4'd2; start_i = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      start_i = 1'b0;
    end
    chk("pre_reset_high", outs(), 4'b1001);
    chk("pre_reset_valid", int'(cap_valid_o), 1);
    reset_ni = 1'b0;
    #1;
    chk("midreset_outs", int'({sm_in_o, sm_reset_o, cap_valid_o, cap_data_o, busy_o, done_o}),
        int'(8'b0_1_0_000_0_0));
    exp_q.delete();
    step(); step();
    reset_ni = 1'b1;
    cap_ready_i = 1'b1;
    hs0 = hs_cnt;
    step();
    chk("after_reset_outs", outs(), 4'b0000);
    chk("after_reset_valid", int'(cap_valid_o), 0);
    step(); step();
    chk("after_reset_no_hs", hs_cnt - hs0, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
